avmm_mux_1to4: RTL and testbench
================================

Name: avmm_mux_1to4

Overview:
Avalon-MM 1-to-4 address-decoding demultiplexer. One upstream host port fans out to four downstream agent ports, selected by two address bits. Read responses route back from the agent that owns the outstanding read. Sits between the LTPI/bridge AVMM host and local register/CSR agents.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of readdata/writedata
SEL_LSB, 12, LSB of the 2-bit agent-select field: sel = m_address[SEL_LSB+1:SEL_LSB]

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
m_address  in  ADDR_WIDTH  host address
m_read  in  1  host read request
m_write  in  1  host write request
m_writedata  in  DATA_WIDTH  host write data
m_byteenable  in  DATA_WIDTH/8  host byte enables
m_readdata  out  DATA_WIDTH  read data returned to host
m_readdatavalid  out  1  read data valid to host
m_waitrequest  out  1  host stall
s_address  out  4*ADDR_WIDTH  per-agent address, agent i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
s_read  out  4  per-agent read
s_write  out  4  per-agent write
s_writedata  out  4*DATA_WIDTH  per-agent write data
s_byteenable  out  4*DATA_WIDTH/8  per-agent byte enables
s_readdata  in  4*DATA_WIDTH  per-agent read data
s_readdatavalid  in  4  per-agent read data valid
s_waitrequest  in  4  per-agent stall

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Internal state: pending (1 bit) and pend_sel (2 bits). Both reset to 0.
- Decode: sel = m_address[SEL_LSB+1:SEL_LSB]. All four agents are always mapped; there is no unmapped region.
- Broadcast: m_address, m_writedata and m_byteenable are copied unmodified (full address) to all four agent slices.
- blocked = reset | (pending & ~s_readdatavalid[pend_sel]).
- Request routing (combinational):
  - s_read[i] = m_read & (sel==i) & ~blocked.
  - s_write[i] = m_write & (sel==i) & ~blocked.
  - Unselected agents see read = write = 0.
- m_waitrequest = blocked ? 1 : s_waitrequest[sel]. It is combinational, so there is zero added latency on the request path.
- A command is accepted on a clk edge when (m_read|m_write) & ~m_waitrequest.
  - The host holds address, data and control stable while m_waitrequest=1 (standard AVMM).
- Read tracking:
  - On an accepted read: pending <= 1, pend_sel <= sel.
  - When pending & s_readdatavalid[pend_sel] and no new read is accepted in that cycle: pending <= 0.
  - If a new read is accepted in the same cycle the previous read completes: pending stays 1 and pend_sel takes the new sel (back-to-back reads with no bubble).
- Response path:
  - m_readdatavalid = pending & s_readdatavalid[pend_sel].
  - m_readdata = s_readdata slice of pend_sel (don't-care when not valid).
  - s_readdatavalid from any agent other than pend_sel, or while pending=0, is ignored.
- Ordering: at most one outstanding read. Any read or write to any agent stalls while a read is pending and not yet completing. Writes never set pending.
- Agent read latency is at least 1 cycle after acceptance. A readdatavalid in the acceptance cycle itself is ignored.
- m_read and m_write both high: illegal host behaviour. The block forwards both to the selected agent and treats the command as a read for tracking.
- Reset mid-transaction: pending is cleared and any in-flight response is dropped. m_readdatavalid=0 in the reset cycle and after.
- Reset output values: m_waitrequest=1, s_read=0, s_write=0, m_readdatavalid=0.

Test Plan:
- Write decode: for each i in 0..3, write 0xA5A5_000i to address i<<12 with s_waitrequest=0 -> exactly s_write[i]=1 for one cycle, data and byteenable 0xF on slice i, other s_write=0.
- Read routing: read address 0x2000; agent 2 returns 0xDEADBEEF with readdatavalid two cycles later -> m_readdatavalid=1 with m_readdata=0xDEADBEEF in that cycle, pending clears afterwards.
- Waitrequest passthrough: agent 1 holds s_waitrequest=1 for 3 cycles on a write to 0x1004 -> m_waitrequest=1 for those 3 cycles, write accepted on the 4th, single s_write[1] acceptance.
- Outstanding-read blocking: read agent 0, then immediately request a write to agent 3 -> m_waitrequest=1 and s_write[3]=0 until agent 0 readdatavalid. A back-to-back read to agent 3 is accepted in the completion cycle.
- Stray response: agent 2 pulses s_readdatavalid with readdata 0x1234 while a read to agent 1 is pending -> m_readdatavalid stays 0 until agent 1 responds with its own data.
- Reset mid-read: assert reset one cycle after a read to agent 3 is accepted, then agent 3 responds -> m_readdatavalid=0, m_waitrequest=1 during reset, and a normal read works after reset is released.

Source files
------------

// File: rtl/avmm_mux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : avmm_mux_1to4
// Brief    : Avalon-MM 1-to-4 address-decoding demux with single-outstanding
//            read tracking and read-response return path.
// Revision : 1.0 - initial release
// ============================================================================
module avmm_mux_1to4 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_LSB    = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       m_address,
  input  logic                        m_read,
  input  logic                        m_write,
  input  logic [DATA_WIDTH-1:0]       m_writedata,
  input  logic [DATA_WIDTH/8-1:0]     m_byteenable,
  output logic [DATA_WIDTH-1:0]       m_readdata,
  output logic                        m_readdatavalid,
  output logic                        m_waitrequest,
  output logic [4*ADDR_WIDTH-1:0]     s_address,
  output logic [3:0]                  s_read,
  output logic [3:0]                  s_write,
  output logic [4*DATA_WIDTH-1:0]     s_writedata,
  output logic [4*DATA_WIDTH/8-1:0]   s_byteenable,
  input  logic [4*DATA_WIDTH-1:0]     s_readdata,
  input  logic [3:0]                  s_readdatavalid,
  input  logic [3:0]                  s_waitrequest
);

  localparam int c_BE_W = DATA_WIDTH / 8;

  logic       r_pending;
  logic [1:0] r_pend_sel;

  logic [1:0] w_sel;
  logic       w_rsp_valid;
  logic       w_blocked;
  logic       w_rd_accept;

  assign w_sel       = m_address[SEL_LSB+1:SEL_LSB];
  assign w_rsp_valid = r_pending & s_readdatavalid[r_pend_sel];
  assign w_blocked   = reset | (r_pending & ~s_readdatavalid[r_pend_sel]);

  assign m_waitrequest = w_blocked | s_waitrequest[w_sel];

  // A read+write collision is tracked as a read so its response is not lost.
  assign w_rd_accept = m_read & ~m_waitrequest;

  // Pending is still set during the synchronous-reset cycle, so gate here.
  assign m_readdatavalid = w_rsp_valid & ~reset;
  assign m_readdata      = s_readdata[r_pend_sel*DATA_WIDTH +: DATA_WIDTH];

  for (genvar gi = 0; gi < 4; gi++) begin : g_agent
    assign s_address[gi*ADDR_WIDTH +: ADDR_WIDTH] = m_address;
    assign s_writedata[gi*DATA_WIDTH +: DATA_WIDTH] = m_writedata;
    assign s_byteenable[gi*c_BE_W +: c_BE_W] = m_byteenable;
    assign s_read[gi]  = m_read  & (w_sel == 2'(gi)) & ~w_blocked;
    assign s_write[gi] = m_write & (w_sel == 2'(gi)) & ~w_blocked;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= 1'b0;
      r_pend_sel <= 2'd0;
    end else if (w_rd_accept) begin
      r_pending  <= 1'b1;
      r_pend_sel <= w_sel;
    end else if (w_rsp_valid) begin
      r_pending  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avmm_mux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : tb_avmm_mux_1to4
// Brief    : Vector table plus directed sequences; read data checked through
//            an expected-response queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avmm_mux_1to4;

  localparam int c_AW = 32;
  localparam int c_DW = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [c_AW-1:0]      m_address;
  logic                 m_read;
  logic                 m_write;
  logic [c_DW-1:0]      m_writedata;
  logic [c_DW/8-1:0]    m_byteenable;
  logic [c_DW-1:0]      m_readdata;
  logic                 m_readdatavalid;
  logic                 m_waitrequest;
  logic [4*c_AW-1:0]    s_address;
  logic [3:0]           s_read;
  logic [3:0]           s_write;
  logic [4*c_DW-1:0]    s_writedata;
  logic [4*c_DW/8-1:0]  s_byteenable;
  logic [4*c_DW-1:0]    s_readdata;
  logic [3:0]           s_readdatavalid;
  logic [3:0]           s_waitrequest;

  avmm_mux_1to4 #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .SEL_LSB(12)) u_dut (
    .clk(clk), .reset(reset),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_waitrequest(m_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_waitrequest(s_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  swait;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_wr;
    logic        exp_wait;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] sb_q[$];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          n_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor on the falling edge, then advance to just past the rising edge.
  task automatic tick();
    logic [31:0] exp_d;
    @(negedge clk);
    if (m_readdatavalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_rdv: got data %0h expected no response", m_readdata);
      end else begin
        exp_d = sb_q.pop_front();
        check("sb_readdata", 64'(m_readdata), 64'(exp_d));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_read = 1'b0;
    m_write = 1'b0;
    m_address = '0;
    m_writedata = '0;
    m_byteenable = 4'hF;
    s_readdatavalid = 4'b0;
    s_waitrequest = 4'b0;
  endtask

  initial begin
    reset = 1'b1;
    s_readdata = '0;
    idle();
    m_read = 1'b1;
    #1;
    tick();
    tick();
    #1;
    check("rst_wait", 64'(m_waitrequest), 64'd1);
    check("rst_sread", 64'(s_read), 64'd0);
    check("rst_swrite", 64'(s_write), 64'd0);
    check("rst_rdv", 64'(m_readdatavalid), 64'd0);
    tick();
    reset = 1'b0;
    idle();

    // ---- vector table: decode / waitrequest routing with nothing pending
    for (int i = 0; i < 4; i++)
      vecs[i] = '{32'(i) << 12, 1'b0, 1'b1, 32'hA5A5_0000 | 32'(i), 4'b0,
                  4'b0, 4'b1 << i, 1'b0};
    vecs[4] = '{32'hFFFF_1ABC, 1'b0, 1'b1, 32'h1111_2222, 4'b0, 4'b0, 4'b0010, 1'b0};
    vecs[5] = '{32'h0000_2000, 1'b1, 1'b0, 32'h0, 4'b0100, 4'b0100, 4'b0, 1'b1};
    vecs[6] = '{32'h0000_3000, 1'b0, 1'b1, 32'h3333_3333, 4'b0100, 4'b0, 4'b1000, 1'b0};
    vecs[7] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0, 4'b0, 1'b0};
    vecs[8] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0, 4'b0001, 4'b0, 4'b0, 1'b1};
    vecs[9] = '{32'h0000_1000, 1'b1, 1'b0, 32'h0, 4'b0010, 4'b0010, 4'b0, 1'b1};

    for (int v = 0; v < 10; v++) begin
      m_address = vecs[v].addr;
      m_read = vecs[v].rd;
      m_write = vecs[v].wr;
      m_writedata = vecs[v].wdata;
      s_waitrequest = vecs[v].swait;
      #1;
      check($sformatf("vec%0d_sread", v), 64'(s_read), 64'(vecs[v].exp_rd));
      check($sformatf("vec%0d_swrite", v), 64'(s_write), 64'(vecs[v].exp_wr));
      check($sformatf("vec%0d_wait", v), 64'(m_waitrequest), 64'(vecs[v].exp_wait));
      if (vecs[v].wr) begin
        for (int a = 0; a < 4; a++) begin
          check($sformatf("vec%0d_wdata%0d", v, a), 64'(s_writedata[a*32 +: 32]), 64'(vecs[v].wdata));
          check($sformatf("vec%0d_addr%0d", v, a), 64'(s_address[a*32 +: 32]), 64'(vecs[v].addr));
        end
        check($sformatf("vec%0d_be", v), 64'(s_byteenable), 64'hFFFF);
      end
      tick();
    end
    idle();
    #1;
    check("after_tbl_swrite", 64'(s_write), 64'd0);

    // ---- read routing, response two cycles after acceptance
    m_read = 1'b1; m_address = 32'h2000;
    #1;
    check("rd2_sread", 64'(s_read), 64'b0100);
    check("rd2_wait", 64'(m_waitrequest), 64'd0);
    sb_q.push_back(32'hDEAD_BEEF);
    tick();
    idle();
    #1;
    check("rd2_blocked", 64'(m_waitrequest), 64'd1);
    check("rd2_nordv", 64'(m_readdatavalid), 64'd0);
    tick();
    s_readdatavalid = 4'b0100; s_readdata[2*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    check("rd2_rdv", 64'(m_readdatavalid), 64'd1);
    check("rd2_data", 64'(m_readdata), 64'hDEAD_BEEF);
    tick();
    idle();
    #1;
    check("rd2_cleared", 64'(m_waitrequest), 64'd0);
    check("rd2_cleared_rdv", 64'(m_readdatavalid), 64'd0);
    tick();

    // ---- waitrequest passthrough on a write to agent 1
    n_acc = 0;
    m_write = 1'b1; m_address = 32'h1004; m_writedata = 32'hCAFE_0001;
    s_waitrequest = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("wp_wait%0d", c), 64'(m_waitrequest), 64'd1);
      if (s_write[1] && !m_waitrequest) n_acc++;
      tick();
    end
    s_waitrequest = 4'b0;
    #1;
    check("wp_wait_release", 64'(m_waitrequest), 64'd0);
    check("wp_swrite", 64'(s_write), 64'b0010);
    if (s_write[1] && !m_waitrequest) n_acc++;
    tick();
    idle();
    check("wp_accept_count", 64'(n_acc), 64'd1);

    // ---- outstanding read blocks a write; write accepted in completion cycle
    m_read = 1'b1; m_address = 32'h0000;
    sb_q.push_back(32'h0BAD_F00D);
    tick();
    m_read = 1'b0; m_write = 1'b1; m_address = 32'h3000;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("blk_wait%0d", c), 64'(m_waitrequest), 64'd1);
      check($sformatf("blk_swrite%0d", c), 64'(s_write), 64'd0);
      tick();
    end
    s_readdatavalid = 4'b0001; s_readdata[0 +: 32] = 32'h0BAD_F00D;
    #1;
    check("blk_done_wait", 64'(m_waitrequest), 64'd0);
    check("blk_done_swrite", 64'(s_write), 64'b1000);
    tick();
    idle();

    // ---- back-to-back read accepted in the completion cycle
    m_read = 1'b1; m_address = 32'h0000;
    sb_q.push_back(32'h0000_0A0A);
    tick();
    m_address = 32'h3000;
    #1;
    check("b2b_blocked", 64'(m_waitrequest), 64'd1);
    check("b2b_sread_blk", 64'(s_read), 64'd0);
    tick();
    s_readdatavalid = 4'b0001; s_readdata[0 +: 32] = 32'h0000_0A0A;
    #1;
    check("b2b_accept_wait", 64'(m_waitrequest), 64'd0);
    check("b2b_accept_sread", 64'(s_read), 64'b1000);
    sb_q.push_back(32'h3333_BEEF);
    tick();
    idle();
    #1;
    check("b2b_still_pending", 64'(m_waitrequest), 64'd1);
    tick();
    s_readdatavalid = 4'b1000; s_readdata[3*32 +: 32] = 32'h3333_BEEF;
    #1;
    check("b2b_rdv3", 64'(m_readdatavalid), 64'd1);
    tick();
    idle();

    // ---- stray responses are ignored
    s_readdatavalid = 4'b0001;
    #1;
    check("stray_idle_rdv", 64'(m_readdatavalid), 64'd0);
    tick();
    idle();
    m_read = 1'b1; m_address = 32'h1000;
    sb_q.push_back(32'h5555_AAAA);
    tick();
    idle();
    s_readdatavalid = 4'b0100; s_readdata[2*32 +: 32] = 32'h0000_1234;
    #1;
    check("stray_rdv", 64'(m_readdatavalid), 64'd0);
    check("stray_wait", 64'(m_waitrequest), 64'd1);
    tick();
    s_readdatavalid = 4'b0010; s_readdata[1*32 +: 32] = 32'h5555_AAAA;
    #1;
    check("stray_own_rdv", 64'(m_readdatavalid), 64'd1);
    check("stray_own_data", 64'(m_readdata), 64'h5555_AAAA);
    tick();
    idle();

    // ---- reset while a read is outstanding
    m_read = 1'b1; m_address = 32'h3000;
    sb_q.push_back(32'h7777_7777);
    tick();
    idle();
    reset = 1'b1;
    sb_q.delete();
    s_readdatavalid = 4'b1000; s_readdata[3*32 +: 32] = 32'h7777_7777;
    #1;
    check("rstmid_wait", 64'(m_waitrequest), 64'd1);
    check("rstmid_rdv", 64'(m_readdatavalid), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rstmid_late_rdv", 64'(m_readdatavalid), 64'd0);
    check("rstmid_unblocked", 64'(m_waitrequest), 64'd0);
    tick();
    idle();
    m_read = 1'b1; m_address = 32'h2000;
    sb_q.push_back(32'h2468_ACE0);
    #1;
    check("post_rst_sread", 64'(s_read), 64'b0100);
    tick();
    idle();
    s_readdatavalid = 4'b0100; s_readdata[2*32 +: 32] = 32'h2468_ACE0;
    #1;
    check("post_rst_rdv", 64'(m_readdatavalid), 64'd1);
    tick();
    idle();
    tick();

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
